// File: rtl/calc_n_pkg.sv
// rtl/calc_n_pkg.sv - command/response encodings and queue-entry type for calc_n_core
package calc_n_pkg;

    localparam int CALC_DATA_W = 32;
    localparam int CALC_TAG_W  = 2;

    localparam logic [3:0] CMD_NOP = 4'd0;
    localparam logic [3:0] CMD_ADD = 4'd1;
    localparam logic [3:0] CMD_SUB = 4'd2;
    localparam logic [3:0] CMD_CMP = 4'd4;
    localparam logic [3:0] CMD_SHL = 4'd5;
    localparam logic [3:0] CMD_SHR = 4'd6;

    localparam logic [1:0] RESP_NONE = 2'd0;
    localparam logic [1:0] RESP_OK   = 2'd1;
    localparam logic [1:0] RESP_ERR  = 2'd2;

    // Packages cannot be parameterised, so the entry follows the package widths.
    typedef struct packed {
        logic [3:0]             cmd;
        logic [CALC_TAG_W-1:0]  tag;
        logic [CALC_DATA_W-1:0] op1;
        logic [CALC_DATA_W-1:0] op2;
    } q_entry_t;

endpackage

// File: rtl/calc_n_if.sv
// rtl/calc_n_if.sv - flattened per-port request/response bundle for calc_n_core
interface calc_n_if #(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = 32,
    parameter int TAG_W     = 2
);
    logic [NUM_PORTS*4-1:0]      req_cmd_in;
    logic [NUM_PORTS*DATA_W-1:0] req_data_in;
    logic [NUM_PORTS*TAG_W-1:0]  req_tag_in;
    logic [NUM_PORTS-1:0]        req_busy;
    logic [NUM_PORTS*2-1:0]      out_resp;
    logic [NUM_PORTS*DATA_W-1:0] out_data;
    logic [NUM_PORTS*TAG_W-1:0]  out_tag;

    modport master (
        output req_cmd_in, req_data_in, req_tag_in,
        input  req_busy, out_resp, out_data, out_tag
    );

    modport slave (
        input  req_cmd_in, req_data_in, req_tag_in,
        output req_busy, out_resp, out_data, out_tag
    );
endinterface

// File: rtl/calc_n_port_queue.sv
// rtl/calc_n_port_queue.sv - per-port two-cycle capture FSM, request FIFO and busy
module calc_n_port_queue
    import calc_n_pkg::*;
#(
    parameter int QDEPTH = 2
) (
    input  logic                   c_clk,
    input  logic                   reset,
    input  logic [3:0]             i_cmd,
    input  logic [CALC_DATA_W-1:0] i_data,
    input  logic [CALC_TAG_W-1:0]  i_tag,
    input  logic                   i_pop,
    output logic                   o_busy,
    output logic                   o_head_vld,
    output q_entry_t               o_head
);
    localparam int AW = $clog2(QDEPTH);

    typedef enum logic {ST_IDLE = 1'b0, ST_OP2 = 1'b1} cap_state_t;

    cap_state_t             r_state;
    logic [3:0]             r_cmd;
    logic [CALC_TAG_W-1:0]  r_tag;
    logic [CALC_DATA_W-1:0] r_op1;
    q_entry_t               r_mem [QDEPTH];
    logic [AW-1:0]          r_wptr;
    logic [AW-1:0]          r_rptr;
    logic [AW:0]            r_count;

    logic w_full;
    logic w_push;
    logic w_accept;

    // Being in OP2 is the reservation, so occupied+reserved==QDEPTH reduces to a full FIFO.
    assign w_full     = (r_count == (AW+1)'(QDEPTH));
    assign w_push     = (r_state == ST_OP2);
    assign w_accept   = (r_state == ST_IDLE) && (i_cmd != CMD_NOP) && !w_full;
    assign o_busy     = w_push || w_full;
    assign o_head_vld = (r_count != '0);
    assign o_head     = r_mem[r_rptr];

    always_ff @(posedge c_clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cmd   <= '0;
            r_tag   <= '0;
            r_op1   <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cmd   <= i_cmd;
                        r_tag   <= i_tag;
                        r_op1   <= i_data;
                        r_state <= ST_OP2;
                    end
                end
                ST_OP2: begin
                    r_mem[r_wptr] <= '{cmd: r_cmd, tag: r_tag, op1: r_op1, op2: i_data};
                    r_wptr        <= r_wptr + AW'(1);
                    r_state       <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
            if (i_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(i_pop);
        end
    end

endmodule

// File: rtl/calc_n_core.sv
// rtl/calc_n_core.sv - N-port calculator: per-port queues, round-robin arbiter, pipelined ALU
// Optional compare command (cmd 4) enabled by defining CALC_N_CMP_EN.
module calc_n_core
    import calc_n_pkg::*;
#(
    parameter int NUM_PORTS = 4,
    parameter int DATA_W    = CALC_DATA_W,
    parameter int QDEPTH    = 2,
    parameter int ALU_LAT   = 2,
    parameter int TAG_W     = CALC_TAG_W
) (
    input logic     c_clk,
    input logic     reset,
    calc_n_if.slave bus
);
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int SW = $clog2(DATA_W);

    q_entry_t             w_head [NUM_PORTS];
    logic [NUM_PORTS-1:0] w_head_vld;
    logic [NUM_PORTS-1:0] w_pop;
    logic                 w_gnt_vld;
    logic [PW-1:0]        w_gnt_idx;
    logic [PW-1:0]        w_ptr_nxt;
    q_entry_t             w_sel;
    logic [DATA_W-1:0]    w_a;
    logic [DATA_W-1:0]    w_b;
    logic [DATA_W:0]      w_sum;
    logic [1:0]           w_alu_resp;
    logic [DATA_W-1:0]    w_alu_data;

    logic [PW-1:0]        r_ptr;
    logic                 r_p_vld  [ALU_LAT];
    logic [PW-1:0]        r_p_port [ALU_LAT];
    logic [1:0]           r_p_resp [ALU_LAT];
    logic [DATA_W-1:0]    r_p_data [ALU_LAT];
    logic [TAG_W-1:0]     r_p_tag  [ALU_LAT];
    logic [1:0]           r_out_resp [NUM_PORTS];
    logic [DATA_W-1:0]    r_out_data [NUM_PORTS];
    logic [TAG_W-1:0]     r_out_tag  [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
        calc_n_port_queue #(.QDEPTH(QDEPTH)) u_queue (
            .c_clk      (c_clk),
            .reset      (reset),
            .i_cmd      (bus.req_cmd_in[g*4 +: 4]),
            .i_data     (bus.req_data_in[g*DATA_W +: DATA_W]),
            .i_tag      (bus.req_tag_in[g*TAG_W +: TAG_W]),
            .i_pop      (w_pop[g]),
            .o_busy     (bus.req_busy[g]),
            .o_head_vld (w_head_vld[g]),
            .o_head     (w_head[g])
        );
        assign w_pop[g]                         = w_gnt_vld && (w_gnt_idx == PW'(g));
        assign bus.out_resp[g*2 +: 2]           = r_out_resp[g];
        assign bus.out_data[g*DATA_W +: DATA_W] = r_out_data[g];
        assign bus.out_tag[g*TAG_W +: TAG_W]    = r_out_tag[g];
    end

    // Round-robin: first valid head scanning upward from the pointer.
    always_comb begin
        logic [PW-1:0] v_idx;
        v_idx     = '0;
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            v_idx = PW'((int'(r_ptr) + i) % NUM_PORTS);
            if (!w_gnt_vld && w_head_vld[v_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = v_idx;
            end
        end
        w_ptr_nxt = r_ptr;
        if (w_gnt_vld) begin
            w_ptr_nxt = PW'((int'(w_gnt_idx) + 1) % NUM_PORTS);
        end
    end

    assign w_sel = w_head[w_gnt_idx];
    assign w_a   = w_sel.op1;
    assign w_b   = w_sel.op2;
    assign w_sum = {1'b0, w_a} + {1'b0, w_b};

    always_comb begin
        w_alu_resp = RESP_ERR;
        w_alu_data = '0;
        case (w_sel.cmd)
            CMD_ADD: begin
                if (!w_sum[DATA_W]) begin
                    w_alu_resp = RESP_OK;
                    w_alu_data = w_sum[DATA_W-1:0];
                end
            end
            CMD_SUB: begin
                if (w_b <= w_a) begin
                    w_alu_resp = RESP_OK;
                    w_alu_data = w_a - w_b;
                end
            end
            CMD_SHL: begin
                w_alu_resp = RESP_OK;
                w_alu_data = w_a << w_b[SW-1:0];
            end
            CMD_SHR: begin
                w_alu_resp = RESP_OK;
                w_alu_data = w_a >> w_b[SW-1:0];
            end
`ifdef CALC_N_CMP_EN
            CMD_CMP: begin
                w_alu_resp = RESP_OK;
                if (w_a < w_b) begin
                    w_alu_data = DATA_W'(1);
                end else if (w_a > w_b) begin
                    w_alu_data = DATA_W'(2);
                end
            end
`else
            CMD_CMP: ;
`endif
            default: ;
        endcase
    end

    // Result is computed in the grant cycle; ALU_LAT stages plus the output register follow.
    always_ff @(posedge c_clk) begin
        if (reset) begin
            r_ptr <= '0;
            for (int k = 0; k < ALU_LAT; k++) begin
                r_p_vld[k] <= 1'b0;
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                r_out_resp[p] <= RESP_NONE;
                r_out_data[p] <= '0;
                r_out_tag[p]  <= '0;
            end
        end else begin
            r_ptr       <= w_ptr_nxt;
            r_p_vld[0]  <= w_gnt_vld;
            r_p_port[0] <= w_gnt_idx;
            r_p_resp[0] <= w_alu_resp;
            r_p_data[0] <= w_alu_data;
            r_p_tag[0]  <= w_sel.tag;
            for (int k = 1; k < ALU_LAT; k++) begin
                r_p_vld[k]  <= r_p_vld[k-1];
                r_p_port[k] <= r_p_port[k-1];
                r_p_resp[k] <= r_p_resp[k-1];
                r_p_data[k] <= r_p_data[k-1];
                r_p_tag[k]  <= r_p_tag[k-1];
            end
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (r_p_vld[ALU_LAT-1] && (r_p_port[ALU_LAT-1] == PW'(p))) begin
                    r_out_resp[p] <= r_p_resp[ALU_LAT-1];
                    r_out_data[p] <= r_p_data[ALU_LAT-1];
                    r_out_tag[p]  <= r_p_tag[ALU_LAT-1];
                end else begin
                    r_out_resp[p] <= RESP_NONE;
                    r_out_data[p] <= '0;
                    r_out_tag[p]  <= '0;
                end
            end
        end
    end

endmodule
